// File: rtl/mips_defs_pkg.sv
// mips_defs: opcode/funct, ALU, state, select encodings and control bundle for the multi-cycle controller
package mips_defs;
  localparam logic [5:0] OP_R = 6'h00, OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_JR = 6'h08;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_OR = 3'b010, ALU_EQ = 3'b011;
  localparam logic       SRCA_PC = 1'b0, SRCA_RS = 1'b1;
  localparam logic [1:0] SRCB_RT = 2'd0, SRCB_4 = 2'd1, SRCB_EXT = 2'd2, SRCB_EXT2 = 2'd3;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] WBS_ALU = 2'd0, WBS_MEM = 2'd1, WBS_PC = 2'd2;
  localparam logic [1:0] PCS_ALU = 2'd0, PCS_TGT = 2'd1, PCS_JIDX = 2'd2, PCS_RS = 2'd3;
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXE_R = 4'd2, S_EXE_I = 4'd3, S_ADDR = 4'd4,
    S_MEM_RD = 4'd5, S_MEM_WR = 4'd6, S_WB_ALU = 4'd7, S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9, S_JUMP = 4'd10
  } state_t;
  typedef enum logic [2:0] {IC_NONE, IC_RALU, IC_IALU, IC_MEM, IC_BEQ, IC_JUMP} iclass_t;
  typedef struct packed {
    iclass_t cls;
    logic    sub;
    logic    lui;
    logic    lw;
    logic    jal;
    logic    jr;
  } dec_t;
  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       reg_we;
    logic       mem_we;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ext_op;
    logic [1:0] reg_dst;
    logic [1:0] wb_src;
    logic [1:0] pc_src;
  } ctrl_t;
endpackage

// File: rtl/mc_controller_if.sv
// mc_if: instruction fields and ALU flag in, datapath controls out, between controller and datapath
interface mc_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        alu_eq;
  logic [31:0] pc_init;
  logic        pc_we;
  logic        ir_we;
  logic        reg_we;
  logic        mem_we;
  logic [2:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  ext_op;
  logic [1:0]  reg_dst;
  logic [1:0]  wb_src;
  logic [1:0]  pc_src;
  logic [3:0]  state;
  modport master (
    input  opcode, funct, alu_eq,
    output pc_init, pc_we, ir_we, reg_we, mem_we, alu_op, alu_src_a, alu_src_b,
           ext_op, reg_dst, wb_src, pc_src, state
  );
  modport slave (
    output opcode, funct, alu_eq,
    input  pc_init, pc_we, ir_we, reg_we, mem_we, alu_op, alu_src_a, alu_src_b,
           ext_op, reg_dst, wb_src, pc_src, state
  );
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode/funct to instruction class and variant flags
module mc_decode
  import mips_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);
  always_comb begin
    dec     = '0;
    dec.sub = funct == FN_SUBU;
    dec.lui = opcode == OP_LUI;
    dec.lw  = opcode == OP_LW;
    dec.jal = opcode == OP_JAL;
    dec.jr  = opcode == OP_R && funct == FN_JR;
    dec.cls = (opcode == OP_R && (funct == FN_ADDU || funct == FN_SUBU)) ? IC_RALU :
              (dec.jr || opcode == OP_J || opcode == OP_JAL)            ? IC_JUMP :
              (opcode == OP_ORI || opcode == OP_LUI)                    ? IC_IALU :
              (opcode == OP_LW || opcode == OP_SW)                      ? IC_MEM  :
              (opcode == OP_BEQ)                                        ? IC_BEQ  : IC_NONE;
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM driving ALU selects and PC/IR/RF/DM write enables
module mc_controller
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic  clk,
  input logic  reset,
  mc_if.master bus
);
  state_t state_q, state_d;
  dec_t   dec;
  ctrl_t  c, ctrl;
  mc_decode u_decode (.opcode(bus.opcode), .funct(bus.funct), .dec(dec));
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = dec.cls == IC_RALU ? S_EXE_R  :
                          dec.cls == IC_IALU ? S_EXE_I  :
                          dec.cls == IC_MEM  ? S_ADDR   :
                          dec.cls == IC_BEQ  ? S_BRANCH :
                          dec.cls == IC_JUMP ? S_JUMP   : S_FETCH;
      S_EXE_R,
      S_EXE_I:  state_d = S_WB_ALU;
      S_ADDR:   state_d = dec.lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_d = S_WB_MEM;
      default:  state_d = S_FETCH;
    endcase
  end
  always_comb begin
    c = '0;
    case (state_q)
      S_FETCH: begin
        c.pc_we     = 1'b1;
        c.ir_we     = 1'b1;
        c.alu_src_b = SRCB_4;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_EXT2;
        c.ext_op    = EXT_SIGN;
      end
      S_EXE_R: begin
        c.alu_src_a = SRCA_RS;
        c.alu_op    = dec.sub ? ALU_SUB : ALU_ADD;
        c.reg_dst   = DST_RD;
      end
      S_EXE_I: begin
        c.alu_src_a = SRCA_RS;
        c.alu_src_b = SRCB_EXT;
        c.ext_op    = dec.lui ? EXT_LUI : EXT_ZERO;
        c.alu_op    = dec.lui ? ALU_ADD : ALU_OR;
      end
      S_ADDR: begin
        c.alu_src_a = SRCA_RS;
        c.alu_src_b = SRCB_EXT;
        c.ext_op    = EXT_SIGN;
      end
      S_MEM_WR: c.mem_we = 1'b1;
      S_WB_ALU: begin
        c.reg_we  = 1'b1;
        c.reg_dst = dec.cls == IC_RALU ? DST_RD : DST_RT;
      end
      S_WB_MEM: begin
        c.reg_we = 1'b1;
        c.wb_src = WBS_MEM;
      end
      S_BRANCH: begin
        c.alu_src_a = SRCA_RS;
        c.alu_op    = ALU_EQ;
        c.pc_we     = bus.alu_eq;
        c.pc_src    = PCS_TGT;
      end
      S_JUMP: begin
        c.pc_we   = 1'b1;
        c.pc_src  = dec.jr ? PCS_RS : PCS_JIDX;
        c.reg_we  = dec.jal;
        c.reg_dst = dec.jal ? DST_RA : DST_RT;
        c.wb_src  = dec.jal ? WBS_PC : WBS_ALU;
      end
      default: c = '0;
    endcase
    // reset masks everything combinationally so nothing fires while it is held
    ctrl = reset ? '0 : c;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  assign bus.pc_init   = RESET_PC;
  assign bus.state     = state_q;
  assign bus.pc_we     = ctrl.pc_we;
  assign bus.ir_we     = ctrl.ir_we;
  assign bus.reg_we    = ctrl.reg_we;
  assign bus.mem_we    = ctrl.mem_we;
  assign bus.alu_op    = ctrl.alu_op;
  assign bus.alu_src_a = ctrl.alu_src_a;
  assign bus.alu_src_b = ctrl.alu_src_b;
  assign bus.ext_op    = ctrl.ext_op;
  assign bus.reg_dst   = ctrl.reg_dst;
  assign bus.wb_src    = ctrl.wb_src;
  assign bus.pc_src    = ctrl.pc_src;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: per-instruction state sequence and control checks against a spec-level model
module tb_mc_controller;
  import mips_defs::*;
  typedef enum {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_BAD} kind_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  mc_if bus ();
  mc_controller #(.RESET_PC(32'h0000_3000)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic ctrl_t actual();
    ctrl_t c;
    c.pc_we = bus.pc_we;         c.ir_we = bus.ir_we;
    c.reg_we = bus.reg_we;       c.mem_we = bus.mem_we;
    c.alu_op = bus.alu_op;       c.alu_src_a = bus.alu_src_a;
    c.alu_src_b = bus.alu_src_b; c.ext_op = bus.ext_op;
    c.reg_dst = bus.reg_dst;     c.wb_src = bus.wb_src;
    c.pc_src = bus.pc_src;
    return c;
  endfunction

  task automatic expected_seq(input kind_t k, output int q[$]);
    case (k)
      K_ADDU, K_SUBU:   q = {0, 1, 2, 7};
      K_ORI, K_LUI:     q = {0, 1, 3, 7};
      K_LW:             q = {0, 1, 4, 5, 8};
      K_SW:             q = {0, 1, 4, 6};
      K_BEQ:            q = {0, 1, 9};
      K_J, K_JAL, K_JR: q = {0, 1, 10};
      default:          q = {0, 1};
    endcase
  endtask

  function automatic ctrl_t exp_ctrl(kind_t k, int st, logic eq);
    ctrl_t c = '0;
    case (st)
      0: begin c.pc_we = 1'b1; c.ir_we = 1'b1; c.alu_src_b = 2'd1; end
      1: begin c.alu_src_b = 2'd3; c.ext_op = 2'd1; end
      2: begin c.alu_src_a = 1'b1; c.alu_op = (k == K_SUBU) ? 3'd1 : 3'd0; c.reg_dst = 2'd1; end
      3: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
        c.ext_op = (k == K_LUI) ? 2'd2 : 2'd0;
        c.alu_op = (k == K_LUI) ? 3'd0 : 3'd2;
      end
      4: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.ext_op = 2'd1; end
      6: c.mem_we = 1'b1;
      7: begin c.reg_we = 1'b1; c.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0; end
      8: begin c.reg_we = 1'b1; c.wb_src = 2'd1; end
      9: begin c.alu_src_a = 1'b1; c.alu_op = 3'd3; c.pc_we = eq; c.pc_src = 2'd1; end
      10: begin
        c.pc_we = 1'b1; c.pc_src = (k == K_JR) ? 2'd3 : 2'd2;
        if (k == K_JAL) begin c.reg_we = 1'b1; c.reg_dst = 2'd2; c.wb_src = 2'd2; end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic enc(input kind_t k, output logic [5:0] op, output logic [5:0] fn);
    logic [5:0] bad_op[4] = '{6'h3f, 6'h01, 6'h00, 6'h08};
    logic [5:0] bad_fn[4] = '{6'h15, 6'h2a, 6'h00, 6'h20};
    int r;
    fn = 6'($urandom);
    case (k)
      K_ADDU: begin op = 6'h00; fn = 6'h21; end
      K_SUBU: begin op = 6'h00; fn = 6'h23; end
      K_JR:   begin op = 6'h00; fn = 6'h08; end
      K_ORI:  op = 6'h0d;
      K_LUI:  op = 6'h0f;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2b;
      K_BEQ:  op = 6'h04;
      K_J:    op = 6'h02;
      K_JAL:  op = 6'h03;
      default: begin r = $urandom_range(0, 3); op = bad_op[r]; if (op == 6'h00) fn = bad_fn[r]; end
    endcase
  endtask

  task automatic run_op(input kind_t k, input logic [5:0] op, input logic [5:0] fn);
    int q[$];
    int regw = 0, memw = 0, want_r, want_m;
    logic eq;
    ctrl_t e, a;
    expected_seq(k, q);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin bus.opcode = op; bus.funct = fn; end
      eq = 1'($urandom_range(0, 1));
      bus.alu_eq = eq;
      #1;
      tests++;
      if (bus.state !== 4'(q[i])) begin
        fails++;
        $display("FAIL state %s step %0d: got %0d want %0d", k.name(), i, bus.state, q[i]);
      end
      e = exp_ctrl(k, q[i], eq);
      a = actual();
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL ctrl %s state %0d: got %h want %h", k.name(), q[i], a, e);
      end
      regw += int'(bus.reg_we);
      memw += int'(bus.mem_we);
    end
    want_r = (k == K_ADDU || k == K_SUBU || k == K_ORI || k == K_LUI || k == K_LW || k == K_JAL) ? 1 : 0;
    want_m = (k == K_SW) ? 1 : 0;
    tests++;
    if (regw !== want_r || memw !== want_m) begin
      fails++;
      $display("FAIL writes %s: got reg %0d mem %0d want reg %0d mem %0d", k.name(), regw, memw, want_r, want_m);
    end
  endtask

  task automatic run(input kind_t k);
    logic [5:0] op, fn;
    enc(k, op, fn);
    run_op(k, op, fn);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    tests++;
    if (bus.state !== 4'd0 || actual() !== ctrl_t'(0)) begin
      fails++;
      $display("FAIL reset_async: got state %0d ctrl %h want 0 0", bus.state, actual());
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.state !== 4'd0 || actual() !== ctrl_t'(0) || bus.pc_init !== 32'h0000_3000) begin
      fails++;
      $display("FAIL reset_hold: got state %0d ctrl %h pc_init %h", bus.state, actual(), bus.pc_init);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (bus.state !== 4'd0 || actual() !== exp_ctrl(K_BAD, 0, 1'b0)) begin
      fails++;
      $display("FAIL reset_release: got state %0d ctrl %h want fetch", bus.state, actual());
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] op, fn;
    enc(K_ADDU, op, fn);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin bus.opcode = op; bus.funct = fn; end
    end
    #1;
    tests++;
    if (bus.state !== 4'd7 || bus.reg_we !== 1'b1) begin
      fails++;
      $display("FAIL mid_wb: got state %0d reg_we %b want 7 1", bus.state, bus.reg_we);
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (bus.state !== 4'd0 || actual() !== ctrl_t'(0)) begin
      fails++;
      $display("FAIL mid_reset: got state %0d ctrl %h want 0 0", bus.state, actual());
    end
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    tests++;
    if (bus.state !== 4'd0 || bus.ir_we !== 1'b1) begin
      fails++;
      $display("FAIL mid_release: got state %0d ir_we %b want 0 1", bus.state, bus.ir_we);
    end
  endtask

  task automatic test_directed();
    run(K_ADDU);
    run(K_LW);
    run(K_SW);
    run(K_BEQ);
    run(K_JAL);
    run(K_JR);
    run_op(K_BAD, 6'h3f, 6'h00);
    run_op(K_BAD, 6'h00, 6'h00);
    run(K_ORI);
    run(K_LUI);
    run(K_SUBU);
    run(K_J);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) run(kind_t'($urandom_range(0, 10)));
  endtask

  task automatic test_idle_return();
    @(negedge clk);
    #1;
    tests++;
    if (bus.state !== 4'd0) begin
      fails++;
      $display("FAIL return_fetch: got state %0d want 0", bus.state);
    end
  endtask

  initial begin
    bus.opcode = 6'h00;
    bus.funct  = 6'h00;
    bus.alu_eq = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    test_idle_return();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
